// File: rtl/sample_pkg.sv
// Shared types and helpers for the sample pipeline stage-2 slice.
package sample_pkg;

  // Default datapath width for operands, FIFO entries and the checksum.
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] data_t;

  // Ceiling log2, used to size FIFO pointers and the occupancy counter.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (remaining > 0) begin
        result    = result + 1;
        remaining = remaining >> 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sample_stage2_sink_if.sv
// Stage-1 -> stage-2 -> stage-4 handshake bundle.
// The master side is whoever feeds stage 2 and consumes its output;
// the slave side is the stage-2 sink itself.
interface sample_stage2_sink_if #(
  parameter int DATA_W = sample_pkg::DATA_W
) ();

  logic              to2_aValid;
  logic [DATA_W-1:0] to2_a;
  logic [DATA_W-1:0] to2_b;
  logic              to3_cValid;
  logic [DATA_W-1:0] to3_c;
  logic              to4_dValid;
  logic              to4_dReady;
  logic [DATA_W-1:0] to4_d;

  modport master (
    output to2_aValid, to2_a, to2_b,
    output to3_cValid, to3_c,
    output to4_dReady,
    input  to4_dValid, to4_d
  );

  modport slave (
    input  to2_aValid, to2_a, to2_b,
    input  to3_cValid, to3_c,
    input  to4_dReady,
    output to4_dValid, to4_d
  );

endinterface

// File: rtl/sample_fifo_sa.sv
// Show-ahead FIFO: head is visible combinationally from the memory,
// occupancy is a registered counter. Pointers carry a wrap bit so full
// and empty are distinguishable with equal low bits.
module sample_fifo_sa
  import sample_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = sample_pkg::DATA_W,
  localparam int AW    = clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr_reg, wr_ptr_next;
  logic [AW:0]       rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0]  level_reg, level_next;

  // Pointer and occupancy next-state; callers only assert push/pop when legal.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // Pointer/occupancy state; contents are left alone on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
    end
  end

  // Storage write; a push while full+pop overwrites the slot being vacated.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level = level_reg;
  assign dout  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/sample_stage2_sink.sv
// Stage-2 sink: sums each a/b pair into a FIFO (no upstream backpressure,
// so overflowing pairs are counted and dropped), presents the head on a
// valid/ready port and keeps a running checksum of popped data and c values.
module sample_stage2_sink
  import sample_pkg::*;
#(
  parameter int DATA_W = sample_pkg::DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  localparam int LVL_W = clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  sample_stage2_sink_if.slave   bus,
  output logic [DATA_W-1:0]     to4_sum,
  output logic [LVL_W-1:0]      fifo_level,
  output logic [CNT_W-1:0]      drop_cnt
);

  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              drop;
  logic [DATA_W-1:0] pair_sum;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] sum_reg, sum_next;
  logic [CNT_W-1:0]  drop_reg, drop_next;

  // Handshake glue: a pop frees a slot, so a push into a full FIFO still lands.
  always_comb begin
    pair_sum = bus.to2_a + bus.to2_b;
    pop      = !fifo_empty && bus.to4_dReady;
    push     = bus.to2_aValid && (!fifo_full || pop);
    drop     = bus.to2_aValid && fifo_full && !pop;
  end

  sample_fifo_sa #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pair_sum),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  // Checksum and saturating drop count next-state.
  always_comb begin
    sum_next  = sum_reg + (pop ? head : '0) + (bus.to3_cValid ? bus.to3_c : '0);
    drop_next = drop_reg;
    if (drop && (drop_reg != {CNT_W{1'b1}})) drop_next = drop_reg + 1'b1;
  end

  // Checksum and drop counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_reg  <= '0;
      drop_reg <= '0;
    end else begin
      sum_reg  <= sum_next;
      drop_reg <= drop_next;
    end
  end

  assign bus.to4_dValid = !fifo_empty;
  assign bus.to4_d      = head;
  assign to4_sum        = sum_reg;
  assign drop_cnt       = drop_reg;

endmodule
